// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared decode constants, field positions, FSM state and per-instruction info
// for the pipeline interlock controller.
package hazard_stall_ctrl_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam int OPC_HI = 31, OPC_LO = 27;
  localparam int RD_HI  = 26, RD_LO  = 22;
  localparam int RS_HI  = 21, RS_LO  = 17;
  localparam int RT_HI  = 16, RT_LO  = 12;
  localparam int AOP_HI = 6,  AOP_LO = 2;

  localparam logic [4:0]  REG_STATUS = 5'd30;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_e;

  // src_mask holds registers whose value must be ready in execute; a store's
  // data register is left out because it is forwarded later from M/W.
  typedef struct packed {
    logic [31:0] src_mask;
    logic [4:0]  rd;
    logic        is_load;
    logic        is_muldiv;
    logic        is_div;
    logic        is_sw;
  } insn_info_t;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle of the interlock controller: latched instructions,
// multdiv ready, and all stall / bubble / multdiv control outputs.
interface hazard_stall_ctrl_if;
  logic [31:0] FDinsn;
  logic [31:0] DXinsn;
  logic        md_ready;
  logic        stall_fetch;
  logic        stall_decode;
  logic        bubble_dx;
  logic        bubble_xm;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic        md_result_valid;
  logic        md_timeout;

  modport master (
    output FDinsn, DXinsn, md_ready,
    input  stall_fetch, stall_decode, bubble_dx, bubble_xm,
           md_ctrl_mult, md_ctrl_div, md_result_valid, md_timeout
  );

  modport slave (
    input  FDinsn, DXinsn, md_ready,
    output stall_fetch, stall_decode, bubble_dx, bubble_xm,
           md_ctrl_mult, md_ctrl_div, md_result_valid, md_timeout
  );
endinterface

// File: rtl/hazard_stall_ctrl_insn_regs_decode.sv
// Register-usage decoder: source-register mask, destination and class flags
// for one instruction. Instantiated once for F/D and once for D/X.
module insn_regs_decode
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [31:0] insn,
  output insn_info_t  info
);
  logic [4:0] opc, rd, rs, rt, aop;
  logic       unused_bits;

  assign opc = insn[OPC_HI:OPC_LO];
  assign rd  = insn[RD_HI:RD_LO];
  assign rs  = insn[RS_HI:RS_LO];
  assign rt  = insn[RT_HI:RT_LO];
  assign aop = insn[AOP_HI:AOP_LO];
  assign unused_bits = ^{insn[11:7], insn[1:0]};

  // NOTE: every field gets a default before the conditional updates, so no
  // path through this block leaves a value held and no latch is inferred.
  always_comb begin
    info           = '0;
    info.rd        = rd;
    info.is_load   = (opc == OP_LW);
    info.is_sw     = (opc == OP_SW);
    info.is_muldiv = (opc == OP_ALU) && (aop == ALU_MUL || aop == ALU_DIV);
    info.is_div    = (opc == OP_ALU) && (aop == ALU_DIV);
    if (opc inside {OP_ALU, OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT})
      info.src_mask[rs] = 1'b1;
    if (opc == OP_ALU)
      info.src_mask[rt] = 1'b1;
    if (opc inside {OP_BNE, OP_BLT, OP_JR})
      info.src_mask[rd] = 1'b1;
    if (opc == OP_BEX)
      info.src_mask[REG_STATUS] = 1'b1;
  end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock: load-use stall plus multdiv IDLE/BUSY/DONE handshake.
// Optional BUSY timeout is enabled with the HAZARD_MD_TIMEOUT_EN macro.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40
) (
  input logic                clock,
  input logic                reset_n,
  hazard_stall_ctrl_if.slave bus
);
  insn_info_t fd_info, dx_info;
  md_state_e  state, state_next;
  logic       load_use, expire, timeout_q;
  logic       sf, sd, bdx, bxm, pulse_mult, pulse_div, res_valid;
  logic       unused_fields;

  insn_regs_decode u_fd_decode (.insn(bus.FDinsn), .info(fd_info));
  insn_regs_decode u_dx_decode (.insn(bus.DXinsn), .info(dx_info));

  assign unused_fields = ^{fd_info.rd, fd_info.is_load, fd_info.is_muldiv,
                           fd_info.is_div, fd_info.is_sw, dx_info.src_mask,
                           dx_info.is_sw};

  assign load_use = dx_info.is_load && (dx_info.rd != '0)
                    && fd_info.src_mask[dx_info.rd];

`ifdef HAZARD_MD_TIMEOUT_EN
  localparam int CNT_W = $clog2(MD_TIMEOUT + 1);
  logic [CNT_W-1:0] busy_cnt;

  // Counter sits at zero outside BUSY, so it is already clear on entry.
  assign expire = (state == MD_BUSY) && !bus.md_ready
                  && (busy_cnt == CNT_W'(MD_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      busy_cnt  <= (state == MD_BUSY) ? busy_cnt + CNT_W'(1) : '0;
      timeout_q <= expire;
    end
  end
`else
  assign expire    = 1'b0;
  assign timeout_q = 1'b0;
`endif

  // NOTE: reset is synchronous, so it is tested inside the clocked block and
  // is absent from the sensitivity list; state uses non-blocking assignment.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= MD_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    sf         = 1'b0;
    sd         = 1'b0;
    bdx        = 1'b0;
    bxm        = 1'b0;
    pulse_mult = 1'b0;
    pulse_div  = 1'b0;
    res_valid  = 1'b0;
    unique case (state)
      MD_IDLE: begin
        if (dx_info.is_muldiv) begin
          pulse_mult = !dx_info.is_div;
          pulse_div  = dx_info.is_div;
          {sf, sd, bxm} = 3'b111;
          state_next = MD_BUSY;
        end else if (load_use) begin
          {sf, bdx} = 2'b11;
        end
      end
      MD_BUSY: begin
        {sf, sd, bxm} = 3'b111;
        if (bus.md_ready || expire) state_next = MD_DONE;
      end
      MD_DONE: begin
        // D/X advances this cycle; the finished op is never restarted.
        res_valid  = 1'b1;
        state_next = MD_IDLE;
        if (load_use) {sf, bdx} = 2'b11;
      end
      default: state_next = MD_IDLE;
    endcase
  end

  assign bus.stall_fetch     = reset_n & sf;
  assign bus.stall_decode    = reset_n & sd;
  assign bus.bubble_dx       = reset_n & bdx;
  assign bus.bubble_xm       = reset_n & bxm;
  assign bus.md_ctrl_mult    = reset_n & pulse_mult;
  assign bus.md_ctrl_div     = reset_n & pulse_div;
  assign bus.md_result_valid = reset_n & res_valid;
  assign bus.md_timeout      = reset_n & (state == MD_DONE) & timeout_q;
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline interlock controller for the 5-stage 32-bit core, the stall side of the forwarding network. It detects hazards that bypass muxes cannot resolve: load-use dependencies, and multi-cycle mult/div occupying execute. For these it freezes PC/F-D/D-X, injects nops, and drives the start/ready handshake with the multdiv unit. It sits in the hazard-logic directory next to the ALU/branch bypass blocks.

## Interface
- MD_TIMEOUT, 40: maximum BUSY cycles waited for multdiv ready (used only with the macro below).
- clock  input  1  core clock; all state changes on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- FDinsn  input  32  instruction in F/D latch.
- DXinsn  input  32  instruction in D/X latch.
- md_ready  input  1  multdiv result ready; level, held until next start.
- stall_fetch  output  1  hold PC and F/D latch.
- stall_decode  output  1  hold D/X latch.
- bubble_dx  output  1  load nop into D/X.
- bubble_xm  output  1  load nop into X/M.
- md_ctrl_mult  output  1  one-cycle mult start pulse.
- md_ctrl_div  output  1  one-cycle div start pulse.
- md_result_valid  output  1  X/M takes multdiv result instead of ALU output.
- md_timeout  output  1  one-cycle flag: multdiv timed out.

## Operation
- Decode: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2]. R-type is opcode 00000. lw is 01000, sw 00111. bne 00010 and blt 00110 read rd and rs. jr 00100 reads rd. bex 10110 reads r30.
- mul/div: opcode 00000 with ALU op 00110 / 00111.
- Load-use: DX is lw with rd≠0, and FD reads that register.
  - FD reads rs for R/I-type, rt for R-type, rd for bne/blt/jr, r30 for bex.
  - Exception: FD is sw and the match is on rd only. No stall; the store data is forwarded from M/W.
- On load-use: stall_fetch=1, bubble_dx=1, stall_decode=0, for exactly one cycle.
- Multdiv FSM, states IDLE, BUSY, DONE:
  - IDLE: if DX is mul/div, pulse md_ctrl_mult/div, assert stall_fetch, stall_decode, bubble_xm, and go to BUSY. Otherwise no multdiv outputs.
  - BUSY: stall_fetch, stall_decode, bubble_xm held at 1. Go to DONE on md_ready=1.
  - DONE: md_result_valid=1, all stalls 0 (D/X advances), go to IDLE.
- Priority: a multdiv stall (IDLE-start or BUSY) suppresses load-use outputs (bubble_dx=0). Load-use is evaluated in IDLE and DONE only.
- DONE always returns to IDLE, so a mul in DX is never restarted. Back-to-back mul/div in the next DX starts afresh from IDLE.
- Reset (reset_n=0 at an edge), including mid-BUSY: state to IDLE, counter to 0. While reset_n=0 all outputs are forced 0.

## Timing
- Start pulse is combinational in the same cycle T that DX shows mul/div in IDLE.
- md_ready first seen high at cycle T+n gives DONE at T+n+1, and the pipeline advances at the end of T+n+1.
- Load-use stall costs exactly 1 cycle.
- All outputs are 0 out of reset, and 0 in IDLE with no hazard.
- md_ready while IDLE or DONE is ignored.

## Configuration
- HAZARD_MD_TIMEOUT_EN defined:
  - A counter (clog2(MD_TIMEOUT+1) bits) counts BUSY cycles, cleared on entering BUSY.
  - On count reaching MD_TIMEOUT without md_ready: go to DONE with md_timeout=1 for that DONE cycle. md_result_valid is still 1, so the writeback exception path sees the result.
- Undefined: no counter, md_timeout tied 0, BUSY waits indefinitely.

## Structure
- Shared package: opcode constants (ALU, lw, sw, bne, blt, jr, bex), ALU op codes for mul/div, field bit ranges, the FSM state enum, and the nop encoding.
- One sub-module: insn_regs_decode. It takes an instruction and returns the source-register mask, destination register, and is_load / is_muldiv / is_sw. It is instantiated twice (FD, DX).

## Test plan
- DX=lw r5 and FD=add r3,r5,r2 → stall_fetch=1, bubble_dx=1 for 1 cycle; all other outputs 0.
- DX=lw r5 and FD=sw r5,0(r1) → no stall. Same DX with FD=sw r7,0(r5) → 1-cycle stall.
- DX=lw r0 and FD=add r3,r0,r0 → no stall.
- DX=mul r4,r1,r2 at T, md_ready high at T+17 → md_ctrl_mult only at T; stalls and bubble_xm T..T+17; md_result_valid at T+18 only.
- div in DX, reset_n=0 at BUSY cycle 5 → all outputs 0 next cycle. After release with DX=nop, state is IDLE and no pulse occurs.
- With HAZARD_MD_TIMEOUT_EN and MD_TIMEOUT=4, mul and md_ready never asserted → md_timeout=1 and md_result_valid=1 five cycles after start, then IDLE.
